// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage owning the PC; fetches over req/ack,
// squashes wrong-path fetches on redirect and halts on a misaligned target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  pcsrc_i,
    input  logic [31:0] pc_e_i,
    input  logic [31:0] ext_imm_e_i,
    input  logic [31:0] rd1_e_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_d_i,
    output logic        instr_valid_d_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pcplus4_d_o,
    output logic        misaligned_target_o
);
    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_e;
    state_e      state_q;
    logic [31:0] pc_q, addr_q, instr_q, pcd_q, pcp4_q;
    logic        req_q, valid_q, mis_q;
    logic        redir_d, bad_d, fault_d;
    logic [31:0] sum_d, tgt_d, nxt_pc_d;

    assign redir_d  = (pcsrc_i == 2'b01) || (pcsrc_i == 2'b10);
    assign sum_d    = (pcsrc_i[1] ? rd1_e_i : pc_e_i) + ext_imm_e_i;
    assign tgt_d    = {sum_d[31:1], sum_d[0] & ~pcsrc_i[1]};
    assign bad_d    = redir_d && (tgt_d[1:0] != 2'b00);
    assign fault_d  = mis_q || bad_d;
    assign nxt_pc_d = redir_d ? tgt_d : pc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            // a redirect retargets the PC and kills Decode's copy even under stall
            if (redir_d && (state_q inside {REQ, HOLD, DRAIN})) begin
                pc_q    <= tgt_d;
                valid_q <= 1'b0;
                mis_q   <= fault_d;
            end
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                REQ: begin
                    if (redir_d && !imem_ack_i) begin
                        state_q <= DRAIN;
                    end else if (redir_d) begin
                        state_q <= bad_d ? FAULT : REQ;
                        req_q   <= !bad_d;
                        addr_q  <= tgt_d;
                    end else if (imem_ack_i) begin
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        instr_q <= imem_rdata_i;
                        pcd_q   <= pc_q;
                        pcp4_q  <= pc_q + 32'd4;
                    end
                end
                HOLD: begin
                    if (redir_d) begin
                        state_q <= bad_d ? FAULT : REQ;
                        req_q   <= !bad_d;
                        addr_q  <= tgt_d;
                    end else if (!stall_d_i) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q + 32'd4;
                        pc_q    <= pc_q + 32'd4;
                        valid_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (imem_ack_i) begin
                        state_q <= fault_d ? FAULT : REQ;
                        req_q   <= !fault_d;
                        addr_q  <= nxt_pc_d;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o          = req_q;
    assign imem_addr_o         = addr_q;
    assign instr_valid_d_o     = valid_q;
    assign instr_d_o           = instr_q;
    assign pc_d_o              = pcd_q;
    assign pcplus4_d_o         = pcp4_q;
    assign misaligned_target_o = mis_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a latency-programmable
// instruction memory model.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic [1:0]  pcsrc = 2'b00;
    logic [31:0] pc_e = '0, imm = '0, rd1 = '0;
    logic        stall = 1'b0;
    logic        ack_m = 1'b0, ack_f = 1'b0, ack;
    logic [31:0] rdata = '0;
    logic        req, valid, mis;
    logic [31:0] addr, instr, pcd, pcp4;

    int checks = 0, failures = 0, cyc = 0, cnt = 0, mem_lat = 1;
    bit mem_en = 1'b1, mem_fix = 1'b1, ok;
    logic [31:0] exp_q[$];
    logic [31:0] e, old;
    int t_prev;

    assign ack = ack_m | ack_f;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk_i(clk), .rst_ni(rst_n), .pcsrc_i(pcsrc), .pc_e_i(pc_e),
        .ext_imm_e_i(imm), .rd1_e_i(rd1), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .stall_d_i(stall),
        .instr_valid_d_o(valid), .instr_d_o(instr), .pc_d_o(pcd),
        .pcplus4_d_o(pcp4), .misaligned_target_o(mis)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // memory: acks mem_lat cycles after a request appears, one-cycle pulse
    initial forever begin
        @(posedge clk);
        #1;
        if (ack_m) begin
            ack_m = 1'b0;
            cnt = 0;
        end else if (mem_en && rst_n && req) begin
            cnt++;
            if (cnt >= mem_lat) begin
                ack_m = 1'b1;
                rdata = mem_fix ? 32'h13 : ~addr;
            end
        end else cnt = 0;
    end

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ack) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req, addr, valid, instr, pcd, pcp4, mis} !== {1'b0, RPC, 1'b0, 96'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got req=%0b addr=%h v=%0b instr=%h pcd=%h pcp4=%h mis=%0b", req, addr, valid, instr, pcd, pcp4, mis);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || addr !== RPC) begin
            failures++;
            $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=%h", req, addr, RPC);
        end
    endtask

    task automatic test_seq;
        mem_fix = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(RPC + 32'(4 * i));
        for (int i = 0; i < 3; i++) begin
            e = exp_q.pop_front();
            wait_ack(ok);
            checks++;
            if (!ok || addr !== e) begin
                failures++;
                $display("FAIL seq_addr%0d got ack=%0b addr=%h exp %h", i, ok, addr, e);
            end
            if (i > 0) begin
                checks++;
                if (cyc - t_prev !== 2) begin
                    failures++;
                    $display("FAIL seq_rate%0d got %0d cycles exp 2", i, cyc - t_prev);
                end
            end
            t_prev = cyc;
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || pcd !== e || pcp4 !== e + 32'd4 || instr !== 32'h13) begin
                failures++;
                $display("FAIL seq_capture%0d got v=%0b pcd=%h pcp4=%h instr=%h exp pcd=%h", i, valid, pcd, pcp4, instr, e);
            end
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        e = RPC + 32'd8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || pcd !== e || instr !== 32'h13 || req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold%0d got v=%0b pcd=%h instr=%h req=%0b exp pcd=%h req=0", i, valid, pcd, instr, req, e);
            end
        end
        stall = 1'b0;
        exp_q.push_back(e + 32'd4);
        e = exp_q.pop_front();
        wait_ack(ok);
        checks++;
        if (!ok || addr !== e) begin
            failures++;
            $display("FAIL stall_release_addr got ack=%0b addr=%h exp %h", ok, addr, e);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pcd !== e) begin
            failures++;
            $display("FAIL stall_release_capture got v=%0b pcd=%h exp %h", valid, pcd, e);
        end
    endtask

    task automatic test_branch;
        stall = 1'b1;
        mem_fix = 1'b0;
        pcsrc = 2'b01;
        pc_e = 32'h0040_0010;
        imm = 32'hFFFF_FFF0;
        exp_q.push_back(pc_e + imm);
        @(negedge clk);
        pcsrc = 2'b00;
        e = exp_q.pop_front();
        checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== e) begin
            failures++;
            $display("FAIL branch_redirect got v=%0b req=%0b addr=%h exp v=0 req=1 addr=%h", valid, req, addr, e);
        end
        wait_ack(ok);
        checks++;
        if (!ok || addr !== e) begin
            failures++;
            $display("FAIL branch_addr got ack=%0b addr=%h exp %h", ok, addr, e);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pcd !== e || instr !== ~e) begin
            failures++;
            $display("FAIL branch_capture got v=%0b pcd=%h instr=%h exp pcd=%h instr=%h", valid, pcd, instr, e, ~e);
        end
    endtask

    task automatic test_jalr_drain;
        old = pcd + 32'd4;
        mem_lat = 3;
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if (req !== 1'b1 || addr !== old || ack !== 1'b0) begin
            failures++;
            $display("FAIL jalr_setup got req=%0b addr=%h ack=%0b exp req=1 addr=%h ack=0", req, addr, ack, old);
        end
        pcsrc = 2'b10;
        rd1 = 32'h0040_0101;
        imm = 32'h3;
        exp_q.push_back((rd1 + imm) & ~32'h1);
        @(negedge clk);
        pcsrc = 2'b00;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            ok = ack;
            checks++;
            if (req !== 1'b1 || addr !== old || valid !== 1'b0) begin
                failures++;
                $display("FAIL jalr_drain%0d got req=%0b addr=%h v=%0b exp req=1 addr=%h v=0", i, req, addr, valid, old);
            end
            if (!ok) @(negedge clk);
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL jalr_drain_ack got none exp ack within 10 cycles");
        end
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (valid !== 1'b0 || req !== 1'b1 || addr !== e) begin
            failures++;
            $display("FAIL jalr_retarget got v=%0b req=%0b addr=%h exp v=0 req=1 addr=%h", valid, req, addr, e);
        end
        wait_ack(ok);
        checks++;
        if (!ok || addr !== e) begin
            failures++;
            $display("FAIL jalr_addr got ack=%0b addr=%h exp %h", ok, addr, e);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pcd !== e || instr !== ~e) begin
            failures++;
            $display("FAIL jalr_capture got v=%0b pcd=%h instr=%h exp pcd=%h", valid, pcd, instr, e);
        end
        mem_lat = 1;
    endtask

    task automatic test_misaligned;
        stall = 1'b1;
        pcsrc = 2'b01;
        pc_e = RPC;
        imm = 32'h2;
        @(negedge clk);
        pcsrc = 2'b00;
        checks++;
        if (mis !== 1'b1 || valid !== 1'b0 || req !== 1'b0) begin
            failures++;
            $display("FAIL misaligned_enter got mis=%0b v=%0b req=%0b exp mis=1 v=0 req=0", mis, valid, req);
        end
        imm = 32'h0;
        for (int i = 0; i < 20; i++) begin
            pcsrc = (i % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (req !== 1'b0 || mis !== 1'b1 || valid !== 1'b0) begin
                failures++;
                $display("FAIL fault_hold%0d got req=%0b mis=%0b v=%0b exp req=0 mis=1 v=0", i, req, mis, valid);
            end
        end
        pcsrc = 2'b00;
        stall = 1'b0;
    endtask

    task automatic test_reset_mid;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req, addr, valid, instr, pcd, pcp4, mis} !== {1'b0, RPC, 1'b0, 96'b0, 1'b0}) begin
            failures++;
            $display("FAIL fault_reset got req=%0b addr=%h v=%0b pcd=%h mis=%0b", req, addr, valid, pcd, mis);
        end
        @(negedge clk);
        mem_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req, addr, valid, instr, pcd, pcp4, mis} !== {1'b0, RPC, 1'b0, 96'b0, 1'b0}) begin
            failures++;
            $display("FAIL midreq_reset got req=%0b addr=%h v=%0b pcd=%h mis=%0b", req, addr, valid, pcd, mis);
        end
        ack_f = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        mem_en = 1'b1;
        exp_q.push_back(RPC);
        @(posedge clk);
        #1 ack_f = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (req !== 1'b1 || addr !== e || valid !== 1'b0) begin
            failures++;
            $display("FAIL late_ack_ignored got req=%0b addr=%h v=%0b exp req=1 addr=%h v=0", req, addr, valid, e);
        end
        wait_ack(ok);
        checks++;
        if (!ok || addr !== e) begin
            failures++;
            $display("FAIL restart_addr got ack=%0b addr=%h exp %h", ok, addr, e);
        end
        @(negedge clk);
        checks++;
        if (valid !== 1'b1 || pcd !== e || pcp4 !== e + 32'd4) begin
            failures++;
            $display("FAIL restart_capture got v=%0b pcd=%h pcp4=%h exp pcd=%h", valid, pcd, pcp4, e);
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_stall();
        test_branch();
        test_jalr_drain();
        test_misaligned();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
